reg_operation_unit: RTL
=======================

Name: reg_operation_unit

Overview:
- Datapath stage directly downstream of the read/write sequencing controller.
- Captures eight input-memory words into an 8-entry register bank, then computes the truncated average and the range (max − min) of the eight words.
- Writes the registered results to output memory at the controller-supplied write address.
- Raises a sticky error flag when the controller's enable sequence is malformed.

Parameters:
DW, 8, width of each input-memory data word and of each result field
AW, 6, width of the output-memory write address

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
data_in  input  DW  input-memory read data, valid in the cycle en_reg is high
en_reg  input  1  write data_in into bank[reg_index]
reg_index  input  3  bank entry select, 0..7
en_op  input  1  compute results from the bank
en_out  input  1  request an output-memory write of the current results
addr_wr  input  AW  output-memory write address, sampled when en_out is high
out_wen  output  1  output-memory write strobe, one-cycle pulse
out_addr  output  AW  output-memory write address
out_avg  output  DW  written data: floor(sum of 8 entries / 8)
out_range  output  DW  written data: max − min of the 8 entries
op_err  output  1  sticky error flag
wr_count  output  4  number of out_wen pulses since reset, saturates at 15

Behaviour:
- Reset (rst=1 at a rising edge):
  - Bank entries, valid mask [7:0], result registers, out_wen, out_addr, out_avg, out_range, op_err, wr_count and the result-fresh flag all become 0.
  - Reset takes priority over every enable in the same cycle.
  - Reset mid-sequence discards partial loads; nothing is written afterwards until a new en_out.
- Bank load:
  - On en_reg: bank[reg_index] <= data_in and valid[reg_index] <= 1.
  - Rewriting an already-valid entry overwrites it silently.
- Operation (en_op), one-cycle latency:
  - Result registers update at the same edge, computed from bank contents before any same-cycle en_reg write.
  - Sum is DW+3 bits wide, no overflow; avg = sum >> 3 (truncation).
  - max and min are unsigned; range = max − min, never negative.
  - valid mask cleared to 0 and result-fresh set to 1.
  - If valid != 8'hFF at en_op: op_err <= 1. Results are still computed from current bank contents, including stale or reset-zero entries.
- Simultaneous en_op and en_reg:
  - The op uses the old bank contents.
  - After the edge, valid = (1 << reg_index), because the load's bit is set after the clear.
- Output write (en_out in cycle N):
  - In cycle N+1: out_wen=1, out_addr = addr_wr sampled at N, out_avg/out_range = result registers as they were at N.
  - In any cycle without a preceding-cycle en_out: out_wen=0, and out_addr/out_avg/out_range hold their last values.
  - wr_count increments on each out_wen pulse and holds at 15.
  - result-fresh cleared at the write.
  - If result-fresh=0 at en_out (no en_op since the last write, or since reset): the write still occurs with the stale results and op_err <= 1.
- Simultaneous en_op and en_out: the write carries the pre-op results, and result-fresh ends at 1 (the new op).
- op_err clears only on rst.
- reg_index is 3 bits, so there is no out-of-range index. addr_wr wrap is the controller's concern; it is passed through unmodified.
- Control ports are pure inputs; there is no backpressure.

Test Plan:
- Load 10,20,30,40,50,60,70,80 into idx 0..7, en_op, en_out with addr_wr=5 -> the cycle after en_out: out_wen=1, out_addr=5, out_avg=45, out_range=70; op_err=0; wr_count=1.
- Load all 8 entries with 255, op, out addr 63 -> out_avg=255 (sum 2040, no overflow), out_range=0, out_addr=63.
- Load only idx 0..6 with 8 (idx 7 still 0 from reset), op, out -> op_err=1, out_avg=7 (56/8), out_range=8.
- en_out twice with no en_op between -> second pulse repeats the previous data, op_err=1, wr_count=2.
- en_op and en_reg(idx 3, data 99) in the same cycle after a full load of 1..8 -> out_avg=4 (36/8), out_range=7; after the edge only valid[3]=1, and a subsequent op without a full reload sets op_err.
- Assert rst for one cycle between loads of idx 3 and 4 -> all outputs 0 and wr_count=0 next cycle; a full reload of 2s, op, out -> out_avg=2, out_range=0, op_err=0.
- Run 16 full load/op/out sequences -> wr_count saturates at 15.

Source files
------------

// File: rtl/reg_operation_unit.sv
`default_nettype none
// ============================================================================
// Module   : reg_operation_unit
// Purpose  : Datapath stage behind the read/write sequencing controller.
//            Loads eight input-memory words into a register bank, computes the
//            truncated average and the unsigned range (max - min) of the bank,
//            and writes the registered results to output memory at the
//            controller-supplied address. A sticky flag reports a malformed
//            enable sequence (op on an incomplete bank, or a write of results
//            that were not refreshed since the last write / reset).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            data_in         - input-memory word, captured when en_reg is high
//            en_reg          - write data_in into bank[reg_index]
//            reg_index       - bank entry select (0..7)
//            en_op           - compute avg/range from the bank
//            en_out          - request an output write of the current results
//            addr_wr         - output write address, sampled with en_out
//            out_wen         - one-cycle output write strobe
//            out_addr        - output write address
//            out_avg         - floor(sum / 8)
//            out_range       - max - min
//            op_err          - sticky sequence error
//            wr_count        - number of writes since reset, saturating at 15
// Revision : 1.0 - initial release
// ============================================================================
module reg_operation_unit #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic          en_reg,
    input  logic [2:0]    reg_index,
    input  logic          en_op,
    input  logic          en_out,
    input  logic [AW-1:0] addr_wr,
    output logic          out_wen,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_avg,
    output logic [DW-1:0] out_range,
    output logic          op_err,
    output logic [3:0]    wr_count
);

    localparam logic [3:0] C_CNT_MAX = 4'd15;

    logic [DW-1:0] bank_q [8];
    logic [7:0]    valid_q;
    logic          fresh_q;
    logic [DW-1:0] res_avg_q;
    logic [DW-1:0] res_range_q;
    logic          out_wen_q;
    logic [AW-1:0] out_addr_q;
    logic [DW-1:0] out_avg_q;
    logic [DW-1:0] out_range_q;
    logic          op_err_q;
    logic [3:0]    wr_count_q;

    logic [DW+2:0] sum_d;
    logic [DW-1:0] max_d;
    logic [DW-1:0] min_d;
    logic [DW+2:0] avg_full_d;
    logic [7:0]    valid_d;

    // Reduction over the registered bank, so an op always sees the contents
    // from before any same-cycle load.
    always_comb begin
        sum_d = '0;
        max_d = bank_q[0];
        min_d = bank_q[0];
        for (int i = 0; i < 8; i++) begin
            sum_d = sum_d + {3'b000, bank_q[i]};
            if (bank_q[i] > max_d) max_d = bank_q[i];
            if (bank_q[i] < min_d) min_d = bank_q[i];
        end
        avg_full_d = sum_d >> 3;
    end

    // The op clears the mask first; a coincident load then re-sets its own bit.
    always_comb begin
        valid_d = en_op ? 8'h00 : valid_q;
        if (en_reg) valid_d[reg_index] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) bank_q[i] <= '0;
            valid_q     <= '0;
            fresh_q     <= 1'b0;
            res_avg_q   <= '0;
            res_range_q <= '0;
            out_wen_q   <= 1'b0;
            out_addr_q  <= '0;
            out_avg_q   <= '0;
            out_range_q <= '0;
            op_err_q    <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            out_wen_q <= en_out;

            if (en_reg) bank_q[reg_index] <= data_in;

            if (en_op) begin
                res_avg_q   <= avg_full_d[DW-1:0];
                res_range_q <= max_d - min_d;
            end

            // The write carries the results as they stand this cycle, so a
            // coincident op only affects the next write.
            if (en_out) begin
                out_addr_q  <= addr_wr;
                out_avg_q   <= res_avg_q;
                out_range_q <= res_range_q;
                if (wr_count_q != C_CNT_MAX) wr_count_q <= wr_count_q + 4'd1;
            end

            if (en_op) begin
                fresh_q <= 1'b1;
            end else if (en_out) begin
                fresh_q <= 1'b0;
            end

            if ((en_op && (valid_q != 8'hFF)) || (en_out && !fresh_q)) begin
                op_err_q <= 1'b1;
            end
        end
    end

    assign out_wen   = out_wen_q;
    assign out_addr  = out_addr_q;
    assign out_avg   = out_avg_q;
    assign out_range = out_range_q;
    assign op_err    = op_err_q;
    assign wr_count  = wr_count_q;

endmodule
`default_nettype wire
